// File: rtl/i2s_trx.sv
// I2S master transceiver: derives sclk/lrck from mclk, serialises a stereo word pair, deserialises the return stream.
// Optional build macro I2S_TRX_LOOPBACK_EN: RX samples the internal TX bit instead of sdata_in.
module i2s_trx #(
  parameter int MCLK_DIV_LRCK = 256,
  parameter int MCLK_DIV_SCLK = 4,
  parameter int PDATA_WIDTH   = 32
) (
  input  logic                   mclk_in,
  input  logic                   rst_in,
  output logic                   lrck_out,
  output logic                   sclk_out,
  input  logic                   sdata_in,
  output logic [PDATA_WIDTH-1:0] pldata_out,
  output logic [PDATA_WIDTH-1:0] prdata_out,
  output logic                   sdata_out,
  input  logic [PDATA_WIDTH-1:0] pldata_in,
  input  logic [PDATA_WIDTH-1:0] prdata_in
);

  localparam int N   = MCLK_DIV_LRCK / (2 * MCLK_DIV_SCLK);
  localparam int W   = PDATA_WIDTH;
  localparam int PHW = $clog2(MCLK_DIV_SCLK);
  localparam int SLW = (2 * N > 2) ? $clog2(2 * N) : 1;

  localparam logic [PHW-1:0] PH_LAST   = PHW'(MCLK_DIV_SCLK - 1);
  localparam logic [PHW-1:0] PH_RISE   = PHW'(MCLK_DIV_SCLK / 2);
  localparam logic [SLW-1:0] SL_LAST   = SLW'(2 * N - 1);
  localparam logic [SLW-1:0] SL_MID    = SLW'(N);
  localparam logic [SLW-1:0] SL_LOAD_L = SLW'(1 % (2 * N));
  localparam logic [SLW-1:0] SL_LOAD_R = SLW'((N + 1) % (2 * N));
  localparam logic [SLW-1:0] SL_RX_L   = SLW'(W % (2 * N));
  localparam logic [SLW-1:0] SL_RX_R   = SLW'((N + W) % (2 * N));

  // cnt is kept split as slot/phase so no divider is needed
  logic [PHW-1:0] ph, ph_nxt;
  logic [SLW-1:0] sl, sl_nxt;
  logic           fall, rise;
  logic [W-1:0]   hold_l, hold_r;
  logic [W-1:0]   tx_sh, rx_sh;
  logic           rx_bit;
  logic           rx_done_l, rx_done_r;

  always_comb begin
    ph_nxt = ph + PHW'(1);
    sl_nxt = sl;
    if (ph == PH_LAST) begin
      ph_nxt = '0;
      sl_nxt = (sl == SL_LAST) ? '0 : sl + SLW'(1);
    end
  end

  // Outputs are registered from the next-count so they line up with cnt itself
  assign fall      = (ph_nxt == '0);
  assign rise      = (ph_nxt == PH_RISE);
  assign sdata_out = tx_sh[W-1];

`ifdef I2S_TRX_LOOPBACK_EN
  assign rx_bit = tx_sh[W-1];
`else
  assign rx_bit = sdata_in;
`endif

  always_ff @(posedge mclk_in) begin
    if (rst_in) begin
      ph         <= '0;
      sl         <= '0;
      sclk_out   <= 1'b0;
      lrck_out   <= 1'b0;
      hold_l     <= '0;
      hold_r     <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_done_l  <= 1'b0;
      rx_done_r  <= 1'b0;
      pldata_out <= '0;
      prdata_out <= '0;
    end else begin
      ph       <= ph_nxt;
      sl       <= sl_nxt;
      sclk_out <= (ph_nxt >= PH_RISE);
      lrck_out <= (sl_nxt >= SL_MID);

      if (fall) begin
        if (sl_nxt == '0) begin
          hold_l <= pldata_in;
          hold_r <= prdata_in;
        end
        if (sl_nxt == SL_LOAD_L)
          tx_sh <= hold_l;
        else if (sl_nxt == SL_LOAD_R)
          tx_sh <= hold_r;
        else
          tx_sh <= tx_sh << 1;
      end

      if (rise)
        rx_sh <= (rx_sh << 1) | W'(rx_bit);

      // publish one mclk after the last bit of each channel is sampled
      rx_done_l <= rise && (sl_nxt == SL_RX_L);
      rx_done_r <= rise && (sl_nxt == SL_RX_R);
      if (rx_done_l)
        pldata_out <= rx_sh;
      if (rx_done_r)
        prdata_out <= rx_sh;
    end
  end

endmodule

// File: tb/tb_i2s_trx.sv
// Directed bench for i2s_trx: a 32-bit and a 24-bit instance, each in external loopback, checked cycle by cycle.
module tb_i2s_trx;

  logic        mclk = 1'b0;
  logic        rst_in;
  logic        lrck1, sclk1, sd1, sdin1;
  logic [31:0] pl_out1, pr_out1, pl_in1, pr_in1;
  logic        lrck2, sclk2, sd2, sdin2;
  logic [23:0] pl_out2, pr_out2, pl_in2, pr_in2;

  always #5 mclk = ~mclk;

  assign sdin1 = sd1;
  assign sdin2 = sd2;

  i2s_trx u_dut32 (
    .mclk_in(mclk), .rst_in(rst_in), .lrck_out(lrck1), .sclk_out(sclk1),
    .sdata_in(sdin1), .pldata_out(pl_out1), .prdata_out(pr_out1),
    .sdata_out(sd1), .pldata_in(pl_in1), .prdata_in(pr_in1)
  );

  i2s_trx #(.PDATA_WIDTH(24)) u_dut24 (
    .mclk_in(mclk), .rst_in(rst_in), .lrck_out(lrck2), .sclk_out(sclk2),
    .sdata_in(sdin2), .pldata_out(pl_out2), .prdata_out(pr_out2),
    .sdata_out(sd2), .pldata_in(pl_in2), .prdata_in(pr_in2)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          tcnt;
  logic [31:0] l1, r1, rp1, epl1, epr1;
  logic [31:0] l2, r2, rp2, epl2, epr2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %h, want %h (frame pos %0d)", tag, obs, want, tcnt);
  endtask

  // expected serial bit in absolute slot k for a word width w (N = 32)
  function automatic logic exp_sd(int w, int k, logic [31:0] l, logic [31:0] r, logic [31:0] rp);
    if (k >= 1 && k <= w) return l[w-k];
    if (k >= 33 && k <= 32 + w) return r[w-(k-32)];
    if (k == 0 && w == 32) return rp[0];
    return 1'b0;
  endfunction

  task automatic model_reset();
    tcnt = 0;
    l1 = '0; r1 = '0; rp1 = '0; epl1 = '0; epr1 = '0;
    l2 = '0; r2 = '0; rp2 = '0; epl2 = '0; epr2 = '0;
  endtask

  task automatic model_step();
    tcnt = (tcnt + 1) % 256;
    if (tcnt == 0) begin
      rp1 = r1; l1 = pl_in1; r1 = pr_in1;
      rp2 = r2; l2 = {8'h0, pl_in2}; r2 = {8'h0, pr_in2};
    end
    if (tcnt == 131) epl1 = l1;
    if (tcnt == 3)   epr1 = rp1;
    if (tcnt == 99)  epl2 = l2;
    if (tcnt == 227) epr2 = r2;
  endtask

  task automatic check_all();
    chk("sclk32", {31'h0, sclk1}, {31'h0, (tcnt % 4) >= 2});
    chk("lrck32", {31'h0, lrck1}, {31'h0, tcnt >= 128});
    chk("sdata32", {31'h0, sd1}, {31'h0, exp_sd(32, tcnt / 4, l1, r1, rp1)});
    chk("pldata32", pl_out1, epl1);
    chk("prdata32", pr_out1, epr1);
    chk("sclk24", {31'h0, sclk2}, {31'h0, (tcnt % 4) >= 2});
    chk("lrck24", {31'h0, lrck2}, {31'h0, tcnt >= 128});
    chk("sdata24", {31'h0, sd2}, {31'h0, exp_sd(24, tcnt / 4, l2, r2, rp2)});
    chk("pldata24", {8'h0, pl_out2}, epl2);
    chk("prdata24", {8'h0, pr_out2}, epr2);
  endtask

  task automatic step();
    logic r;
    r = rst_in;
    @(posedge mclk);
    #1;
    if (r) model_reset();
    else model_step();
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int hi;
    int first_hi;
    rst_in = 1'b1;
    pl_in1 = '0; pr_in1 = '0; pl_in2 = '0; pr_in2 = '0;
    model_reset();

    // reset for two edges, then clocks and zero loopback for four frames
    run(2);
    rst_in = 1'b0;
    chk("rst_sclk", {31'h0, sclk1}, 32'h0);
    chk("rst_lrck", {31'h0, lrck1}, 32'h0);
    chk("rst_pl", pl_out1, 32'h0);
    chk("rst_pr", pr_out1, 32'h0);
    run(4 * 256);

    // data loopback, inputs changed mid-frame afterwards
    pl_in1 = 32'hA5A5_0F0F; pr_in1 = 32'h8000_0001;
    pl_in2 = 24'h123456;    pr_in2 = 24'h00F00F;
    run(256);
    run(200);
    pl_in1 = 32'h8000_0000; pr_in1 = 32'h0;
    run(56 + 100);
    chk("loop_pl", pl_out1, 32'hA5A5_0F0F);
    chk("loop_pr", pr_out1, 32'h8000_0001);
    chk("narrow_pl", {8'h0, pl_out2}, 32'h0012_3456);
    chk("narrow_pr", {8'h0, pr_out2}, 32'h0000_F00F);
    run(156);

    // serial format: single MSB on the left channel
    hi = 0;
    first_hi = -1;
    for (int i = 0; i < 256; i++) begin
      if (sd1) begin
        hi++;
        if (first_hi < 0) first_hi = tcnt;
      end
      step();
    end
    chk("fmt_hi_count", hi, 32'd4);
    chk("fmt_first_hi", first_hi, 32'd4);
    chk("fmt_pl", pl_out1, 32'h8000_0000);
    chk("fmt_pr", pr_out1, 32'h0);

    // mid-frame reset at cnt = 100
    pl_in1 = 32'h1357_9BDF; pr_in1 = 32'h2468_ACE0;
    run(100);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk("mid_rst_sclk", {31'h0, sclk1}, 32'h0);
    chk("mid_rst_lrck", {31'h0, lrck1}, 32'h0);
    chk("mid_rst_sdata", {31'h0, sd1}, 32'h0);
    chk("mid_rst_pl", pl_out1, 32'h0);
    chk("mid_rst_pr", pr_out1, 32'h0);
    chk("mid_rst_pl24", {8'h0, pl_out2}, 32'h0);
    run(2 * 256 + 4);
    chk("post_rst_pl", pl_out1, 32'h1357_9BDF);
    chk("post_rst_pr", pr_out1, 32'h2468_ACE0);
    chk("post_rst_pl24", {8'h0, pl_out2}, 32'h0012_3456);
    chk("post_rst_pr24", {8'h0, pr_out2}, 32'h0000_F00F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
